lcd_controller: RTL and testbench

LCD_CONTROLLER -- requirements
Module: lcd_controller

---
 rtl/lcd_pkg.sv | 46 ++++
 rtl/lcd_req_fifo.sv | 43 ++++
 rtl/lcd_controller.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_controller.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared FSM state type and command constants for the HD44780-style LCD controller.
// LCD_INIT_SEQ_EN adds the power-on init states.
package lcd_pkg;

`ifdef LCD_INIT_SEQ_EN
  typedef enum logic [2:0] {
    StIdle, StSetup, StPulse, StHold, StWait, StInitPwr, StInitCmd
  } lcd_state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StSetup, StPulse, StHold, StWait
  } lcd_state_e;
`endif

  // Commands that need the long execution wait.
  localparam logic [7:0] CmdClear   = 8'h01;
  localparam logic [7:0] CmdHome    = 8'h02;
  localparam logic [7:0] CmdHomeAlt = 8'h03;

  // Power-on init command ROM, issued in this order.
  localparam logic [7:0] InitFuncSet   = 8'h38;
  localparam logic [7:0] InitDispOn    = 8'h0C;
  localparam logic [7:0] InitClear     = 8'h01;
  localparam logic [7:0] InitEntryMode = 8'h06;
  localparam int unsigned InitLen      = 4;

  function automatic logic [7:0] init_cmd(logic [1:0] idx);
    logic [7:0] cmd;
    unique case (idx)
      2'd0: cmd = InitFuncSet;
      2'd1: cmd = InitDispOn;
      2'd2: cmd = InitClear;
      2'd3: cmd = InitEntryMode;
    endcase
    return cmd;
  endfunction

  function automatic logic is_long_cmd(logic rs, logic [7:0] data);
    return !rs && ((data == CmdClear) || (data == CmdHome) || (data == CmdHomeAlt));
  endfunction

  function automatic int unsigned max2(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// Synchronous request FIFO; power-of-two depth, extra pointer bit distinguishes full from empty.
module lcd_req_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (PtrW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/lcd_controller.sv
// Buffered write-only LCD bus controller: SETUP/PULSE/HOLD/WAIT strobe sequencer per request.
// Define LCD_INIT_SEQ_EN to add the power-up wait and built-in init command sequence.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned PULSE_CYC  = 12,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned EXEC_CYC   = 2000,
  parameter int unsigned CLEAR_CYC  = 82000,
  parameter int unsigned FIFO_DEPTH = 4
`ifdef LCD_INIT_SEQ_EN
  ,
  parameter int unsigned POWERUP_CYC = 750000
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_vld,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_req_rdy,
  output logic       o_busy,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

`ifdef LCD_INIT_SEQ_EN
  localparam int unsigned LongCyc = max2(CLEAR_CYC, POWERUP_CYC);
`else
  localparam int unsigned LongCyc = CLEAR_CYC;
`endif
  localparam int unsigned MaxCyc = max2(max2(max2(SETUP_CYC, PULSE_CYC),
                                             max2(HOLD_CYC, EXEC_CYC)), LongCyc);
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  function automatic logic [CntW-1:0] ld(int unsigned n);
    return CntW'(n - 1);
  endfunction

  lcd_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic rs_q, rs_d;
  logic en_q, on_q;
  logic init_done;
  logic fifo_full, fifo_empty, fifo_pop;
  logic [8:0] fifo_rdata;

`ifdef LCD_INIT_SEQ_EN
  logic [2:0] idx_q, idx_d;
  logic init_done_q, init_done_d;
  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

  lcd_req_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(9)
  ) u_req_fifo (
    .clk_i  (i_clk),
    .reset_i(i_reset),
    .push_i (i_req_vld),
    .wdata_i({i_req_rs, i_req_data}),
    .full_o (fifo_full),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    rs_d     = rs_q;
    fifo_pop = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    idx_d       = idx_q;
    init_done_d = init_done_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && init_done) begin
          fifo_pop       = 1'b1;
          {rs_d, data_d} = fifo_rdata;
          state_d        = StSetup;
          cnt_d          = ld(SETUP_CYC);
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = ld(PULSE_CYC);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = ld(HOLD_CYC);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StWait;
          cnt_d   = is_long_cmd(rs_q, data_q) ? ld(CLEAR_CYC) : ld(EXEC_CYC);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
`ifdef LCD_INIT_SEQ_EN
          if (!init_done_q) begin
            if (idx_q == 3'(InitLen)) begin
              init_done_d = 1'b1;
              state_d     = StIdle;
            end else begin
              state_d = StInitCmd;
            end
          end else
`endif
          // Chain straight into the next strobe when work is queued.
          if (!fifo_empty) begin
            fifo_pop       = 1'b1;
            {rs_d, data_d} = fifo_rdata;
            state_d        = StSetup;
            cnt_d          = ld(SETUP_CYC);
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`ifdef LCD_INIT_SEQ_EN
      // Reset leaves the counter at zero, so the power-up wait counts up instead.
      StInitPwr: begin
        if (cnt_q == CntW'(POWERUP_CYC - 1)) begin
          state_d = StInitCmd;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StInitCmd: begin
        data_d  = init_cmd(idx_q[1:0]);
        rs_d    = 1'b0;
        idx_d   = idx_q + 3'd1;
        state_d = StSetup;
        cnt_d   = ld(SETUP_CYC);
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
`ifdef LCD_INIT_SEQ_EN
      state_q     <= StInitPwr;
      idx_q       <= '0;
      init_done_q <= 1'b0;
`else
      state_q <= StIdle;
`endif
      cnt_q  <= '0;
      data_q <= '0;
      rs_q   <= 1'b0;
      en_q   <= 1'b0;
      on_q   <= 1'b0;
    end else begin
`ifdef LCD_INIT_SEQ_EN
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
`endif
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= (state_d == StPulse);
      on_q    <= 1'b1;
    end
  end

  assign o_req_rdy   = !fifo_full;
  assign o_busy      = (state_q != StIdle) || !fifo_empty;
  assign o_init_done = init_done;
  assign o_lcd_data  = data_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_q;
  assign o_lcd_on    = on_q;

endmodule

// File: tb/tb_lcd_controller.sv
// Self-checking bench for lcd_controller; a strobe monitor checks bus bytes against a queue.
module tb_lcd_controller;

  localparam int unsigned SetupCyc  = 1;
  localparam int unsigned PulseCyc  = 3;
  localparam int unsigned HoldCyc   = 1;
  localparam int unsigned ExecCyc   = 5;
  localparam int unsigned ClearCyc  = 20;
  localparam int unsigned FifoDepth = 4;
`ifdef LCD_INIT_SEQ_EN
  localparam int unsigned PowerupCyc = 10;
  localparam logic ResetBusy = 1'b1;
  localparam logic ResetDone = 1'b0;
`else
  localparam logic ResetBusy = 1'b0;
  localparam logic ResetDone = 1'b1;
`endif
  localparam int StrobeGap = SetupCyc + PulseCyc + HoldCyc + ExecCyc;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_req_vld = 1'b0;
  logic       i_req_rs = 1'b0;
  logic [7:0] i_req_data = 8'h00;
  logic       o_req_rdy, o_busy, o_init_done, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
  logic [7:0] o_lcd_data;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [8:0] exp_q[$];
  int         rises[$];
  bit         abort_strobe = 1'b0;
  logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_controller #(
    .SETUP_CYC (SetupCyc),
    .PULSE_CYC (PulseCyc),
    .HOLD_CYC  (HoldCyc),
    .EXEC_CYC  (ExecCyc),
    .CLEAR_CYC (ClearCyc),
    .FIFO_DEPTH(FifoDepth)
`ifdef LCD_INIT_SEQ_EN
    ,
    .POWERUP_CYC(PowerupCyc)
`endif
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_req_vld  (i_req_vld),
    .i_req_rs   (i_req_rs),
    .i_req_data (i_req_data),
    .o_req_rdy  (o_req_rdy),
    .o_busy     (o_busy),
    .o_init_done(o_init_done),
    .o_lcd_data (o_lcd_data),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_on   (o_lcd_on)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pops the expected byte on each EN rise, then checks bus stability and pulse width.
  task automatic monitor();
    logic prev_en;
    int hi_len;
    logic [8:0] held;
    prev_en = 1'b0;
    hi_len = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (o_lcd_en === 1'b1 && prev_en !== 1'b1) begin
        rises.push_back(cyc);
        held = {o_lcd_rs, o_lcd_data};
        hi_len = 1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected got %h want none", held);
        end else if (held !== exp_q[0]) begin
          errors++;
          $display("FAIL strobe_byte got %h want %h", held, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end else if (o_lcd_en === 1'b1) begin
        hi_len++;
        checks++;
        if ({o_lcd_rs, o_lcd_data} !== held) begin
          errors++;
          $display("FAIL strobe_stable got %h want %h", {o_lcd_rs, o_lcd_data}, held);
        end
      end else if (prev_en === 1'b1) begin
        if (!abort_strobe) begin
          checks++;
          if (hi_len != PulseCyc) begin
            errors++;
            $display("FAIL en_width got %0d want %0d", hi_len, PulseCyc);
          end
        end
        abort_strobe = 1'b0;
      end
      prev_en = o_lcd_en;
    end
  endtask

  task automatic push_req(input logic rs, input logic [7:0] data, output int waited);
    @(negedge clk);
    i_req_vld  = 1'b1;
    i_req_rs   = rs;
    i_req_data = data;
    waited = 0;
    while (o_req_rdy !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (o_req_rdy === 1'b1) begin
      exp_q.push_back({rs, data});
    end else begin
      checks++;
      errors++;
      $display("FAIL push_timeout got rdy=%b want 1", o_req_rdy);
    end
    @(posedge clk);
    #1 i_req_vld = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy !== 1'b0 && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout got busy=%b want 0", o_busy);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    i_reset   = 1'b1;
    i_req_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    exp_q.delete();
    rises.delete();
    @(negedge clk);
    i_reset = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, init_seq[i]});
`endif
  endtask

  task automatic wait_ready();
    int n;
`ifdef LCD_INIT_SEQ_EN
    n = 0;
    while (o_init_done !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (o_init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_timeout got done=%b want 1", o_init_done);
    end
`endif
    wait_idle(n);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (o_lcd_en !== 1'b0 || o_lcd_data !== 8'h00 || o_lcd_rs !== 1'b0 || o_lcd_rw !== 1'b0) begin
      errors++;
      $display("FAIL %s_bus got en=%b data=%h rs=%b rw=%b want 0 00 0 0", tag, o_lcd_en,
               o_lcd_data, o_lcd_rs, o_lcd_rw);
    end
    checks++;
    if (o_lcd_on !== 1'b0) begin
      errors++;
      $display("FAIL %s_on got %b want 0", tag, o_lcd_on);
    end
    checks++;
    if (o_req_rdy !== 1'b1 || o_busy !== ResetBusy) begin
      errors++;
      $display("FAIL %s_fifo got rdy=%b busy=%b want 1 %b", tag, o_req_rdy, o_busy, ResetBusy);
    end
    checks++;
    if (o_init_done !== ResetDone) begin
      errors++;
      $display("FAIL %s_init_done got %b want %b", tag, o_init_done, ResetDone);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    release_reset();
    @(posedge clk);
    #1;
    checks++;
    if (o_lcd_on !== 1'b1 || o_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got on=%b rdy=%b want 1 1", o_lcd_on, o_req_rdy);
    end
  endtask

`ifdef LCD_INIT_SEQ_EN
  task automatic test_init();
    int c0, n, w, t_done;
    apply_reset();
    release_reset();
    c0 = cyc;
    push_req(1'b1, 8'h5A, w);
    checks++;
    if (o_init_done !== 1'b0) begin
      errors++;
      $display("FAIL init_early got %b want 0", o_init_done);
    end
    n = 0;
    while (o_init_done !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    t_done = cyc - c0;
    checks++;
    if (t_done != PowerupCyc + 4 * (1 + SetupCyc + PulseCyc + HoldCyc) + 3 * ExecCyc + ClearCyc)
    begin
      errors++;
      $display("FAIL init_time got %0d want %0d", t_done,
               PowerupCyc + 4 * (1 + SetupCyc + PulseCyc + HoldCyc) + 3 * ExecCyc + ClearCyc);
    end
    wait_idle(n);
    checks++;
    if (rises.size() != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL init_strobes got %0d left=%0d want 5 0", rises.size(), exp_q.size());
    end else if (rises[4] <= t_done + c0) begin
      errors++;
      $display("FAIL init_order got rise=%0d want after %0d", rises[4], t_done + c0);
    end
  endtask
`endif

  task automatic test_single();
    int n, w;
    push_req(1'b1, 8'h41, w);
    wait_idle(n);
    checks++;
    if (n != 1 + StrobeGap) begin
      errors++;
      $display("FAIL single_latency got %0d want %0d", n, 1 + StrobeGap);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_missing got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_exec_time();
    logic [7:0] ops [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int n, w, want;
    for (int i = 0; i < 4; i++) begin
      push_req(1'b0, ops[i], w);
      wait_idle(n);
      want = 1 + SetupCyc + PulseCyc + HoldCyc + ((i < 3) ? ClearCyc : ExecCyc);
      checks++;
      if (n != want) begin
        errors++;
        $display("FAIL cmd_%h_latency got %0d want %0d", ops[i], n, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w [6];
    int n;
    rises.delete();
    for (int i = 0; i < 6; i++) begin
      push_req(1'b1, 8'hA0 + 8'(i), w[i]);
      if (i == 4) begin
        checks++;
        if (o_req_rdy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_full got rdy=%b want 0", o_req_rdy);
        end
      end
    end
    checks++;
    if (w[0] + w[1] + w[2] + w[3] + w[4] != 0 || w[5] == 0) begin
      errors++;
      $display("FAIL b2b_stall got %0d %0d want 0 >0", w[0] + w[1] + w[2] + w[3] + w[4], w[5]);
    end
    wait_idle(n);
    checks++;
    if (rises.size() != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got %0d left=%0d want 6 0", rises.size(), exp_q.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (rises[i] - rises[i-1] != StrobeGap) begin
          errors++;
          $display("FAIL b2b_gap%0d got %0d want %0d", i, rises[i] - rises[i-1], StrobeGap);
        end
      end
    end
  endtask

  task automatic test_push_pop();
    int n, w, k;
    rises.delete();
    for (int i = 0; i < 4; i++) push_req(1'b1, 8'hC0 + 8'(i), w);
    k = 0;
    while (o_lcd_en === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    // First strobe just ended; time the next push onto the WAIT-exit pop edge.
    repeat (HoldCyc + ExecCyc - 1) @(posedge clk);
    push_req(1'b1, 8'hC4, w);
    checks++;
    if (w != 0 || o_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL pushpop_occ3 got wait=%0d rdy=%b want 0 1", w, o_req_rdy);
    end
    push_req(1'b1, 8'hC5, w);
    checks++;
    if (w != 0 || o_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_occ4 got wait=%0d rdy=%b want 0 0", w, o_req_rdy);
    end
    wait_idle(n);
    checks++;
    if (rises.size() != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL pushpop_count got %0d left=%0d want 6 0", rises.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_pulse();
    int w, k;
    push_req(1'b1, 8'h11, w);
    push_req(1'b1, 8'h22, w);
    push_req(1'b1, 8'h33, w);
    k = 0;
    while (o_lcd_en !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    abort_strobe = 1'b1;
    apply_reset();
    check_reset_outputs("midpulse");
    release_reset();
    wait_ready();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
`ifdef LCD_INIT_SEQ_EN
    test_init();
`endif
    wait_ready();
    test_single();
    test_exec_time();
    test_back_to_back();
    test_push_pop();
    test_reset_mid_pulse();
    test_single();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
